instruction_memory_block: RTL and testbench
===========================================

INSTRUCTION_MEMORY_BLOCK -- requirements
Module: instruction_memory

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit instruction words stored.
REQ-002 Parameter WIDTH, default 32: instruction word width in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1: rising-edge clock for all state updates.
REQ-005 Port rst  input  1: synchronous active-high reset; reloads the boot image.
REQ-006 Port pc  input  32: word address of the instruction to fetch; pc+1 is the next word.
REQ-007 Port we  input  1: program-load write enable.
REQ-008 Port waddr  input  32: word address for program-load writes.
REQ-009 Port wdata  input  WIDTH: instruction word to write.
REQ-010 Port inst  output  WIDTH: fetched instruction word.
REQ-011 Port addr_err  output  1: high when pc is outside 0..DEPTH-1.

Function
REQ-012 Storage SHALL be a DEPTH x WIDTH word array, word-addressed with no byte offset and no alignment check.
REQ-013 Reads SHALL be combinational: inst = mem[pc] when pc < DEPTH, settling within the same delta/cycle as any pc change, with no clock needed.
REQ-014 For pc >= DEPTH (upper bits nonzero), inst SHALL be 0x00000000 (NOP) and addr_err SHALL be 1; otherwise addr_err SHALL be 0.
REQ-015 On a rising clk edge with rst=1, the array SHALL be loaded with the boot image.
REQ-016 Boot image: word0=0x20080005, word1=0x20090003, word2=0x01095020, word3=0x01095822, word4=0xAC0A0000, word5=0x8C0C0000, word6=0x1000FFFF, words 7..DEPTH-1=0x00000000.
REQ-017 On a rising clk edge with rst=0 and we=1 and waddr < DEPTH, mem[waddr] SHALL become wdata.
REQ-018 A write with waddr >= DEPTH SHALL be ignored without side effects.
REQ-019 Write data SHALL NOT appear on inst before the clock edge; after the edge, inst SHALL reflect the new word combinationally if pc = waddr.
REQ-020 rst SHALL take priority over we in the same cycle, so the word takes its boot-image value.
REQ-021 While rst is held, inst SHALL follow pc combinationally over the boot image.
REQ-022 Contents before the first reset edge SHALL be don't-care; every bench SHALL reset first.
REQ-023 The pc, waddr and wdata inputs SHALL have no other effect; there is no read enable and no latency other than combinational.

Reset
REQ-024 Reset SHALL affect only the array contents; outputs are combinational functions of pc and the contents and have no separate reset value.
REQ-025 After one reset edge with pc=0, inst SHALL be 0x20080005 and addr_err SHALL be 0.
REQ-026 Asserting reset mid-program SHALL discard all prior writes at the next edge.

Verification
REQ-027 Sequential fetch: reset, then pc=0,1,2,3,4 stepped every 50 ns -> inst=0x20080005, 0x20090003, 0x01095020, 0x01095822, 0xAC0A0000, each immediately after the pc change.
REQ-028 Program load: we=1, waddr=10, wdata=0xDEADBEEF, one edge, pc=10 -> inst=0xDEADBEEF; before the edge, pc=10 -> 0x00000000.
REQ-029 Out of range: pc=256 and pc=0xFFFFFFFF -> inst=0x00000000, addr_err=1; pc=255 -> addr_err=0.
REQ-030 Reset/write collision: rst=1, we=1, waddr=0, wdata=0x12345678, one edge -> pc=0 gives 0x20080005.
REQ-031 Reset mid-operation: write 0xCAFEF00D to word 7, then reset -> pc=7 gives 0x00000000.
REQ-032 Ignored write: we=1, waddr=300, one edge -> pc=44 (300 mod 256) still reads 0x00000000.

Source files
------------

// File: rtl/instruction_memory_block.sv
// Instruction memory: word-addressed DEPTH x WIDTH array.
// Reads are combinational and out-of-range fetches return a NOP with addr_err raised.
// Writes load the program synchronously.
// Reset reloads a fixed boot image.
module instruction_memory_block #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc,
  input  logic             we,
  input  logic [31:0]      waddr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] inst,
  output logic             addr_err
);

  // Index width; a one-word memory still needs a one-bit index.
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DepthW = 32'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             pc_ok;
  logic             waddr_ok;

  // Boot program: a short arithmetic/store/load sequence ending in a branch-to-self.
  function automatic logic [WIDTH-1:0] boot_word(input int unsigned idx);
    logic [31:0] w;
    case (idx)
      0:       w = 32'h2008_0005;
      1:       w = 32'h2009_0003;
      2:       w = 32'h0109_5020;
      3:       w = 32'h0109_5822;
      4:       w = 32'hAC0A_0000;
      5:       w = 32'h8C0C_0000;
      6:       w = 32'h1000_FFFF;
      default: w = 32'h0000_0000;
    endcase
    return WIDTH'(w);
  endfunction

  // Full 32-bit range compares so nonzero upper address bits never alias into the array.
  assign pc_ok    = (pc < DepthW);
  assign waddr_ok = (waddr < DepthW);

  // Combinational fetch; out-of-range returns a NOP and raises addr_err.
  always_comb begin
    inst     = '0;
    addr_err = ~pc_ok;
    if (pc_ok) begin
      inst = mem[pc[AW-1:0]];
    end
  end

  // Reset reloads the boot image and takes priority over program-load writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[AW'(i)] <= boot_word(i);
      end
    end else if (we && waddr_ok) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: tb/tb_instruction_memory_block.sv
// Self-checking bench for instruction_memory_block: vector table, directed corner
// sequences and randomized traffic against an array-based reference model.
module tb_instruction_memory_block;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [31:0] inst;
  logic        addr_err;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] model [DEPTH];
  logic [31:0] boot_img [7];
  logic [31:0] rpc;
  logic [31:0] exp_w;
  logic        exp_e;
  logic        do_rst;

  instruction_memory_block #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .inst     (inst),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic model_boot();
    for (int i = 0; i < DEPTH; i++) model[i] = (i < 7) ? boot_img[i] : 32'h0;
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] w, output logic e);
    if (a < DEPTH) begin
      w = model[a];
      e = 1'b0;
    end else begin
      w = 32'h0;
      e = 1'b1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    boot_img[0] = 32'h2008_0005; boot_img[1] = 32'h2009_0003;
    boot_img[2] = 32'h0109_5020; boot_img[3] = 32'h0109_5822;
    boot_img[4] = 32'hAC0A_0000; boot_img[5] = 32'h8C0C_0000;
    boot_img[6] = 32'h1000_FFFF;

    vecs[0]  = '{32'd0,        32'h2008_0005, 1'b0};
    vecs[1]  = '{32'd1,        32'h2009_0003, 1'b0};
    vecs[2]  = '{32'd2,        32'h0109_5020, 1'b0};
    vecs[3]  = '{32'd3,        32'h0109_5822, 1'b0};
    vecs[4]  = '{32'd4,        32'hAC0A_0000, 1'b0};
    vecs[5]  = '{32'd5,        32'h8C0C_0000, 1'b0};
    vecs[6]  = '{32'd6,        32'h1000_FFFF, 1'b0};
    vecs[7]  = '{32'd7,        32'h0000_0000, 1'b0};
    vecs[8]  = '{32'd255,      32'h0000_0000, 1'b0};
    vecs[9]  = '{32'd256,      32'h0000_0000, 1'b1};
    vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[11] = '{32'h0001_0000, 32'h0000_0000, 1'b1};

    rst = 1'b1; we = 1'b0; pc = 32'd0; waddr = 32'd0; wdata = 32'd0;

    // First reset edge, then follow pc while reset is still held.
    @(posedge clk); #1;
    chk("reset_pc0_inst", inst, 32'h2008_0005);
    chk("reset_pc0_err", {31'd0, addr_err}, 32'd0);
    pc = 32'd2; #1;
    chk("reset_held_pc2", inst, 32'h0109_5020);
    @(negedge clk);
    rst = 1'b0;

    // Vector table, pc stepped every 50 ns and sampled just after each change.
    for (int i = 0; i < 12; i++) begin
      pc = vecs[i].pc; #1;
      chk($sformatf("vec%0d_inst", i), inst, vecs[i].exp_inst);
      chk($sformatf("vec%0d_err", i), {31'd0, addr_err}, {31'd0, vecs[i].exp_err});
      #49;
    end

    // Program load: new word invisible before the edge, visible right after.
    @(negedge clk);
    pc = 32'd10; we = 1'b1; waddr = 32'd10; wdata = 32'hDEAD_BEEF; #1;
    chk("load_before_edge", inst, 32'h0000_0000);
    @(posedge clk); #1;
    chk("load_after_edge", inst, 32'hDEAD_BEEF);
    @(negedge clk);
    we = 1'b0;

    // Reset/write collision: reset wins; earlier program load is also discarded.
    rst = 1'b1; we = 1'b1; waddr = 32'd0; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 1'b0; we = 1'b0;
    pc = 32'd0; #1;
    chk("collision_pc0", inst, 32'h2008_0005);
    pc = 32'd10; #1;
    chk("collision_discard10", inst, 32'h0000_0000);

    // Reset mid-operation discards a write to word 7.
    @(negedge clk);
    we = 1'b1; waddr = 32'd7; wdata = 32'hCAFE_F00D; pc = 32'd7;
    @(posedge clk); #1;
    chk("mid_write7", inst, 32'hCAFE_F00D);
    @(negedge clk);
    we = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset7", inst, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;

    // Out-of-range write must not alias onto 300 mod 256.
    we = 1'b1; waddr = 32'd300; wdata = 32'h5A5A_A5A5; pc = 32'd44;
    @(posedge clk); #1;
    chk("ignored_write44", inst, 32'h0000_0000);
    @(negedge clk);
    we = 1'b1; waddr = 32'h8000_0003; wdata = 32'h1111_2222; pc = 32'd3;
    @(posedge clk); #1;
    chk("ignored_write_hi3", inst, 32'h0109_5822);
    @(negedge clk);
    we = 1'b0;

    // Randomized traffic against the reference model.
    model_boot();
    for (int n = 0; n < 400; n++) begin
      do_rst = ($urandom_range(0, 39) == 0);
      rst    = do_rst;
      we     = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0:       waddr = $urandom;
        1:       waddr = $urandom_range(DEPTH, DEPTH + 100);
        default: waddr = $urandom_range(0, DEPTH - 1);
      endcase
      wdata = $urandom;
      case ($urandom_range(0, 4))
        0:       pc = $urandom;
        1:       pc = waddr;
        default: pc = $urandom_range(0, DEPTH - 1);
      endcase
      rpc = pc;
      #1;
      model_read(rpc, exp_w, exp_e);
      chk("rand_pre_inst", inst, exp_w);
      chk("rand_pre_err", {31'd0, addr_err}, {31'd0, exp_e});
      @(posedge clk);
      if (do_rst) model_boot();
      else if (we && waddr < DEPTH) model[waddr] = wdata;
      #1;
      model_read(rpc, exp_w, exp_e);
      chk("rand_post_inst", inst, exp_w);
      chk("rand_post_err", {31'd0, addr_err}, {31'd0, exp_e});
      @(negedge clk);
    end
    rst = 1'b0; we = 1'b0;

    // Sweep the whole array against the model.
    for (int a = 0; a < DEPTH; a++) begin
      pc = a; #1;
      chk($sformatf("sweep%0d", a), inst, model[a]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
